// File: rtl/neuron_serial.sv
// neuron_serial: time-multiplexed neuron. One (input, weight) pair is multiplied
// and accumulated per accepted handshake; after N elements the ReLU of the
// accumulated sum (bias + sum of products) is presented on a valid/ready port.
// Arithmetic is modular in ACCW bits so results match the parallel neuron bit for bit.
module neuron_serial #(
  parameter int N  = 2,
  parameter int QM = 12,
  parameter int QN = 20,
  parameter int WM = 6,
  parameter int WN = 10,
  parameter int OB = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [QM+QN-1:0]     in_data,
  input  logic [WM+WN-1:0]     weight,
  input  logic                 bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OB-1:0]        out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int DW   = QM + QN;
  localparam int WW   = WM + WN;
  localparam int ACCW = DW + N;
  localparam int CW   = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state_reg;
  logic [ACCW-1:0] acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic [OB-1:0]   out_reg;
  logic            out_valid_reg;

  logic [ACCW-1:0] data_ext;
  logic [ACCW-1:0] weight_ext;
  logic [ACCW-1:0] prod;
  logic [ACCW-1:0] acc_base;
  logic [ACCW-1:0] acc_next;
  logic            accept;
  logic            last;

  // Only the low ACCW bits of the product are ever kept, and those depend only
  // on the low ACCW bits of each operand, so the multiply is done at ACCW width
  // on sign-extended (or truncated) operands.
  assign data_ext = {{(ACCW-DW){in_data[DW-1]}}, in_data};

  generate
    if (WW < ACCW) begin : g_wext
      assign weight_ext = {{(ACCW-WW){weight[WW-1]}}, weight};
    end else begin : g_wtrunc
      assign weight_ext = weight[ACCW-1:0];
    end
  endgenerate

  assign prod = data_ext * weight_ext;

  // The first element of an evaluation starts from the bias instead of the stale accumulator.
  assign acc_base = (cnt_reg == '0) ? {{(ACCW-1){1'b0}}, bias} : acc_reg;
  assign acc_next = acc_base + prod;

  assign last      = (cnt_reg == CW'(N - 1));
  // Held low during reset so nothing is offered as accepted while rst_n is asserted.
  assign in_ready  = rst_n && (state_reg != DONE);
  assign accept    = in_valid && in_ready;
  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (cnt_reg != '0) || out_valid_reg;

  // Control FSM plus accumulator, counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACC: begin
          if (accept) begin
            acc_reg <= acc_next;
            if (last) begin
              cnt_reg       <= '0;
              out_reg       <= acc_next[ACCW-1] ? '0 : acc_next[OB-1:0];
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              cnt_reg   <= cnt_reg + CW'(1);
              state_reg <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_serial.sv
// Bench for neuron_serial: directed scenarios plus randomized evaluations.
// Expected results are pushed into a queue when stimulus is issued and a
// separate monitor pops and compares on every output handshake.
module tb_neuron_serial;

  localparam int N  = 2;
  localparam int QM = 12;
  localparam int QN = 20;
  localparam int WM = 6;
  localparam int WN = 10;
  localparam int OB = 8;
  localparam int ACCW = QM + QN + N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [QM+QN-1:0]  in_data = '0;
  logic [WM+WN-1:0]  weight = '0;
  logic              bias = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OB-1:0]     out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;

  int checks = 0;
  int passes = 0;
  logic [OB-1:0] exp_q[$];
  bit rand_ready = 1'b0;

  neuron_serial #(.N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN), .OB(OB)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .weight(weight), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: integer sum, wrapped to an ACCW-bit two's-complement value, then ReLU and keep OB bits.
  function automatic logic [OB-1:0] model(input logic b, input logic [QM+QN-1:0] a0,
                                          input logic [WM+WN-1:0] w0,
                                          input logic [QM+QN-1:0] a1,
                                          input logic [WM+WN-1:0] w1);
    longint x0, x1, y0, y1, s, modv, half, wrapped;
    x0 = $signed(a0); y0 = $signed(w0);
    x1 = $signed(a1); y1 = $signed(w1);
    s = longint'(b) + x0 * y0 + x1 * y1;
    modv = longint'(1) << ACCW;
    half = longint'(1) << (ACCW - 1);
    wrapped = s % modv;
    if (wrapped < 0) wrapped += modv;
    if (wrapped >= half) return '0;
    return OB'(wrapped % (longint'(1) << OB));
  endfunction

  // Present one element and hold it until accepted (bounded wait).
  task automatic send(input logic [QM+QN-1:0] a, input logic [WM+WN-1:0] w, input logic b);
    bit took;
    int guard;
    in_data = a; weight = w; bias = b; in_valid = 1'b1;
    took = 1'b0; guard = 0;
    while (!took) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        $display("FAIL send_timeout: got no accept expected accept");
        checks++;
        took = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_data = $urandom; weight = 16'($urandom); bias = 1'($urandom);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  // Monitor: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic [OB-1:0] e;
        e = exp_q.pop_front();
        check("scoreboard_out", out, e);
        $display("result out=%0d expected=%0d", out, e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OB-1:0] held;

    // Reset state
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    // Basic back-to-back evaluation
    out_ready = 1'b1;
    exp_q.push_back(model(1'b0, 3, 2, 5, 1));
    send(3, 2, 1'b0);
    send(5, 1, 1'b0);
    check("basic_latency_valid", out_valid, 1);
    check("basic_out", out, 11);
    @(posedge clk); #1;
    check("basic_valid_drop", out_valid, 0);
    check("basic_in_ready", in_ready, 1);

    // Bias plus a two-cycle bubble
    exp_q.push_back(model(1'b1, 3, 2, 5, 1));
    send(3, 2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      check("bubble_busy", busy, 1);
      check("bubble_no_valid", out_valid, 0);
    end
    send(5, 1, 1'b0);
    check("bias_out", out, 12);
    idle(1);

    // ReLU clamps a negative sum
    exp_q.push_back(model(1'b0, 32'hFFFF_FFFC, 3, 1, 2));
    send(32'hFFFF_FFFC, 3, 1'b0);
    send(1, 2, 1'b0);
    check("relu_valid", out_valid, 1);
    check("relu_out", out, 0);
    idle(1);

    // Output keeps only the low OB bits
    exp_q.push_back(model(1'b0, 150, 2, 0, 0));
    send(150, 2, 1'b0);
    send(0, 0, 1'b0);
    check("trunc_out", out, 44);
    idle(1);

    // Backpressure: result held, no element taken while DONE
    out_ready = 1'b0;
    exp_q.push_back(model(1'b0, 4, 4, 2, 3));
    send(4, 4, 1'b0);
    send(2, 3, 1'b0);
    held = out;
    check("bp_first_out", out, 22);
    in_data = 9; weight = 9; bias = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("bp_out_stable", out, held);
      check("bp_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(1);
    check("bp_valid_drop", out_valid, 0);
    check("bp_nothing_taken", busy, 0);

    // Asynchronous reset mid-evaluation discards the partial sum
    send(7, 7, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out", out, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(1'b0, 3, 2, 5, 1));
    send(3, 2, 1'b0);
    send(5, 1, 1'b0);
    check("arst_after_out", out, 11);
    idle(1);

    // Randomized evaluations with random bubbles and backpressure
    rand_ready = 1'b1;
    for (int e = 0; e < 40; e++) begin
      logic [QM+QN-1:0] a0, a1;
      logic [WM+WN-1:0] w0, w1;
      logic b;
      a0 = $urandom; a1 = $urandom;
      w0 = 16'($urandom); w1 = 16'($urandom);
      if ((e % 4) == 0) begin a0 = 32'($urandom_range(0, 300)); w0 = 16'($urandom_range(0, 20)); end
      b = 1'($urandom);
      exp_q.push_back(model(b, a0, w0, a1, w1));
      send(a0, w0, b);
      idle($urandom_range(0, 2));
      send(a1, w1, 1'($urandom));
    end
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    check("queue_drained", exp_q.size(), 0);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
